// File: rtl/fir_tdf_param_if.sv
// Sample, coefficient-load and output bundle for fir_tdf_param.
// The master drives samples and control; the slave is the filter.
interface fir_tdf_param_if #(
  parameter int DW  = 8,
  parameter int CW  = 8,
  parameter int OW  = 16,
  parameter int AWD = 3
);
  logic                  clr;
  logic                  xin_valid;
  logic signed [DW-1:0]  xin;
  logic                  coef_we;
  logic        [AWD-1:0] coef_addr;
  logic signed [CW-1:0]  coef_data;
  logic                  sat_en;
  logic                  ovf_clr;
  logic                  yout_valid;
  logic signed [OW-1:0]  yout;
  logic                  ovf;

  modport master (
    output clr, xin_valid, xin, coef_we, coef_addr, coef_data, sat_en, ovf_clr,
    input  yout_valid, yout, ovf
  );

  modport slave (
    input  clr, xin_valid, xin, coef_we, coef_addr, coef_data, sat_en, ovf_clr,
    output yout_valid, yout, ovf
  );
endinterface

// File: rtl/fir_tdf_param.sv
// Parametrised transposed-direct-form FIR with run-time coefficients,
// valid-gated flow, scaled saturating/wrapping output and sticky overflow.
module fir_tdf_param #(
  parameter int NTAPS = 8,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int OW    = 16,
  parameter int SHIFT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_tdf_param_if.slave bus
);
  localparam int AWD = $clog2(NTAPS);
  localparam int AW  = DW + CW + $clog2(NTAPS);
  localparam int SW  = (AW > OW) ? AW : OW;

  localparam logic signed [OW-1:0] Y_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] Y_MIN = {1'b1, {(OW-1){1'b0}}};

  logic signed [CW-1:0] h_q  [NTAPS];
  logic signed [AW-1:0] prod [NTAPS];
  logic signed [AW-1:0] q_q  [1:NTAPS-1];
  logic signed [AW-1:0] q_d  [1:NTAPS-1];
  logic signed [AW-1:0] acc;
  logic signed [SW-1:0] s_ext;
  logic signed [OW-1:0] yout_q, yout_d;
  logic                 yout_valid_q;
  logic                 ovf_q, ovf_d;
  logic                 fits;
  logic                 accept;
  logic                 coef_hit;
  logic [AWD-1:0]       coef_addr;

  // A sample presented together with clr is dropped, so it cannot raise ovf.
  assign accept    = bus.xin_valid & ~bus.clr;
  assign coef_addr = bus.coef_addr;
  assign coef_hit  = bus.coef_we && (int'(coef_addr) < NTAPS);

  always_comb begin
    // NOTE: every variable here gets a value on every path before any
    // conditional override, so no latch can be inferred.
    for (int k = 0; k < NTAPS; k++) begin
      prod[k] = AW'(h_q[k]) * AW'(bus.xin);
    end
    q_d[NTAPS-1] = prod[NTAPS-1];
    for (int k = 1; k < NTAPS-1; k++) begin
      q_d[k] = q_q[k+1] + prod[k];
    end
    acc   = q_q[1] + prod[0];
    s_ext = SW'(acc >>> SHIFT);

    // Fits in OW bits when every bit from the OW-1 sign position up agrees.
    fits   = (&s_ext[SW-1:OW-1]) | ~(|s_ext[SW-1:OW-1]);
    yout_d = s_ext[OW-1:0];
    if (!fits && bus.sat_en) begin
      yout_d = s_ext[SW-1] ? Y_MIN : Y_MAX;
    end

    ovf_d = ovf_q;
    if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (accept && !fits) begin
      ovf_d = 1'b1;
    end
  end

  // NOTE: the coefficient file is built from flops, not RAM, because reset
  // must load it with the identity response h[0]=1, h[1..]=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        h_q[k] <= CW'(k == 0);
      end
    end else if (coef_hit) begin
      h_q[coef_addr] <= bus.coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make each register take the pre-edge
    // value of its neighbour, which the transposed chain relies on.
    if (!rst_n) begin
      q_q          <= '{default: '0};
      yout_q       <= '0;
      yout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (bus.clr) begin
        q_q          <= '{default: '0};
        yout_q       <= '0;
        yout_valid_q <= 1'b0;
      end else begin
        yout_valid_q <= bus.xin_valid;
        if (bus.xin_valid) begin
          q_q    <= q_d;
          yout_q <= yout_d;
        end
      end
    end
  end

  assign bus.yout       = yout_q;
  assign bus.yout_valid = yout_valid_q;
  assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_fir_tdf_param.sv
// Scoreboarded bench for fir_tdf_param: expected outputs are queued when a
// sample is accepted and compared when yout_valid is seen.
module tb_fir_tdf_param;
  localparam int NTAPS = 8;
  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int OW    = 16;
  localparam int AWD   = 3;

  typedef logic signed [DW-1:0] samp_t;
  typedef logic signed [CW-1:0] coef_t;
  typedef logic signed [OW-1:0] out_t;

  localparam coef_t IMP_H  [NTAPS] = '{-8'sd2, -8'sd1, 8'sd3, 8'sd4, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
  localparam out_t  IMP_Y  [9]     = '{-16'sd2, -16'sd1, 16'sd3, 16'sd4, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd0};
  localparam coef_t ID_H   [NTAPS] = '{8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
  localparam coef_t ALL127 [NTAPS] = '{default: 8'sd127};
  localparam coef_t ALLM128[NTAPS] = '{default: -8'sd128};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_tdf_param_if #(.DW(DW), .CW(CW), .OW(OW), .AWD(AWD)) bus ();
  fir_tdf_param_if #(.DW(DW), .CW(CW), .OW(OW), .AWD(AWD)) bus_s ();

  // The SHIFT=1 instance sees exactly the same stimulus.
  assign bus_s.clr       = bus.clr;
  assign bus_s.xin_valid = bus.xin_valid;
  assign bus_s.xin       = bus.xin;
  assign bus_s.coef_we   = bus.coef_we;
  assign bus_s.coef_addr = bus.coef_addr;
  assign bus_s.coef_data = bus.coef_data;
  assign bus_s.sat_en    = bus.sat_en;
  assign bus_s.ovf_clr   = bus.ovf_clr;

  fir_tdf_param #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  fir_tdf_param #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  int    tests_run    = 0;
  int    tests_failed = 0;
  out_t  exp_q [$];
  out_t  mon_exp;
  coef_t tb_h [NTAPS];

  function automatic out_t sat16(input longint s, input bit sat);
    out_t w;
    w = out_t'(s);
    if (sat && s > 64'sd32767)       w = 16'sh7fff;
    else if (sat && s < -64'sd32768) w = 16'sh8000;
    return w;
  endfunction

  // Scoreboard monitor: outputs are registered, so the falling edge is safe.
  always @(negedge clk) begin
    if (bus.yout_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard: unexpected output yout=%0d, expected no output", bus.yout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.yout !== mon_exp) begin
          tests_failed++;
          $display("FAIL scoreboard yout: got %0d, expected %0d", bus.yout, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // All tasks start and end just after a falling edge.
  task automatic accept(input samp_t x, input out_t exp_y);
    bus.xin_valid = 1'b1;
    bus.xin       = x;
    exp_q.push_back(exp_y);
    @(posedge clk);
    @(negedge clk);
    bus.xin_valid = 1'b0;
    tests_run++;
    if (bus.yout_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency yout_valid: got %b, expected 1", bus.yout_valid);
    end
  endtask

  task automatic gap_check(input out_t held);
    bus.xin_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.yout_valid !== 1'b0 || bus.yout !== held) begin
      tests_failed++;
      $display("FAIL gap hold: got valid=%b yout=%0d, expected valid=0 yout=%0d",
               bus.yout_valid, bus.yout, held);
    end
  endtask

  task automatic write_coef(input int k, input coef_t v);
    bus.coef_we   = 1'b1;
    bus.coef_addr = AWD'(k);
    bus.coef_data = v;
    tb_h[k]       = v;
    @(posedge clk);
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic load_coefs(input coef_t h [NTAPS]);
    for (int k = 0; k < NTAPS; k++) write_coef(k, h[k]);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clr = 1'b0;
    tests_run++;
    if (bus.yout_valid !== 1'b0 || bus.yout !== 16'sd0) begin
      tests_failed++;
      $display("FAIL clr outputs: got valid=%b yout=%0d, expected valid=0 yout=0",
               bus.yout_valid, bus.yout);
    end
  endtask

  task automatic pulse_ovf_clr();
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ovf_clr = 1'b0;
  endtask

  task automatic check_ovf(input string name, input logic exp_ovf);
    tests_run++;
    if (bus.ovf !== exp_ovf) begin
      tests_failed++;
      $display("FAIL %s ovf: got %b, expected %b", name, bus.ovf, exp_ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.yout !== 16'sd0 || bus.yout_valid !== 1'b0 || bus.ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset state: got yout=%0d valid=%b ovf=%b, expected 0 0 0",
               bus.yout, bus.yout_valid, bus.ovf);
    end
    tests_run++;
    if (bus_s.yout !== 16'sd0 || bus_s.yout_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset state shift1: got yout=%0d valid=%b, expected 0 0",
               bus_s.yout, bus_s.yout_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tb_h = ID_H;
  endtask

  task automatic test_impulse();
    do_clr();
    load_coefs(IMP_H);
    for (int i = 0; i < 9; i++) accept(samp_t'(i == 0), IMP_Y[i]);
  endtask

  task automatic test_stall();
    do_clr();
    for (int i = 0; i < 9; i++) begin
      accept(samp_t'(i == 0), IMP_Y[i]);
      gap_check(IMP_Y[i]);
    end
  endtask

  task automatic test_coef_collision();
    load_coefs(ID_H);
    do_clr();
    bus.coef_we   = 1'b1;
    bus.coef_addr = '0;
    bus.coef_data = 8'sd2;
    accept(8'sd5, 16'sd5);
    bus.coef_we = 1'b0;
    tb_h[0] = 8'sd2;
    accept(8'sd5, 16'sd10);
    write_coef(0, 8'sd1);
  endtask

  task automatic test_saturation();
    do_clr();
    load_coefs(ALL127);
    bus.sat_en = 1'b1;
    for (int n = 1; n <= 10; n++) accept(8'sd127, sat16(longint'((n < 8 ? n : 8) * 16129), 1'b1));
    check_ovf("sat127", 1'b1);
    bus.sat_en = 1'b0;
    accept(8'sd127, -16'sd2040);
    accept(8'sd127, -16'sd2040);
    check_ovf("wrap127", 1'b1);
    bus.sat_en = 1'b1;
    do_clr();
    check_ovf("clr keeps", 1'b1);
    load_coefs(ALLM128);
    for (int n = 1; n <= 9; n++) accept(-8'sd128, sat16(longint'((n < 8 ? n : 8) * 16384), 1'b1));
  endtask

  task automatic test_reset_midstream();
    bus.xin_valid = 1'b1;
    bus.xin       = -8'sd128;
    @(posedge clk);
    #1;
    bus.xin_valid = 1'b0;
    tests_run++;
    if (bus.yout !== 16'sd32767 || bus.ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre-reset outputs: got yout=%0d ovf=%b, expected 32767 1", bus.yout, bus.ovf);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.yout !== 16'sd0 || bus.yout_valid !== 1'b0 || bus.ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL midstream reset: got yout=%0d valid=%b ovf=%b, expected 0 0 0",
               bus.yout, bus.yout_valid, bus.ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tb_h = ID_H;
    @(negedge clk);
    accept(8'sd7, 16'sd7);
    tests_run++;
    if (bus_s.yout !== 16'sd3) begin
      tests_failed++;
      $display("FAIL post-reset shift1 yout: got %0d, expected 3", bus_s.yout);
    end
  endtask

  task automatic test_ovf_clr();
    load_coefs(ALL127);
    do_clr();
    bus.sat_en = 1'b1;
    accept(8'sd127, 16'sd16129);
    accept(8'sd127, 16'sd32258);
    accept(8'sd127, 16'sd32767);
    check_ovf("overflow set", 1'b1);
    pulse_ovf_clr();
    check_ovf("ovf_clr", 1'b0);
    bus.ovf_clr = 1'b1;
    accept(8'sd127, 16'sd32767);
    bus.ovf_clr = 1'b0;
    check_ovf("set wins", 1'b1);
    pulse_ovf_clr();
    check_ovf("ovf_clr again", 1'b0);
  endtask

  task automatic test_shift();
    load_coefs(ID_H);
    do_clr();
    accept(-8'sd3, -16'sd3);
    tests_run++;
    if (bus_s.yout !== -16'sd2 || bus_s.yout_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL shift1 yout: got %0d valid=%b, expected -2 valid=1",
               bus_s.yout, bus_s.yout_valid);
    end
  endtask

  task automatic test_clr();
    load_coefs(IMP_H);
    do_clr();
    accept(8'sd1, -16'sd2);
    accept(8'sd2, -16'sd5);
    accept(8'sd3, -16'sd5);
    bus.clr       = 1'b1;
    bus.xin_valid = 1'b1;
    bus.xin       = 8'sd9;
    @(posedge clk);
    @(negedge clk);
    bus.clr       = 1'b0;
    bus.xin_valid = 1'b0;
    tests_run++;
    if (bus.yout_valid !== 1'b0 || bus.yout !== 16'sd0) begin
      tests_failed++;
      $display("FAIL clr discards sample: got valid=%b yout=%0d, expected 0 0",
               bus.yout_valid, bus.yout);
    end
    for (int i = 0; i < 9; i++) accept(samp_t'(i == 0), IMP_Y[i]);
  endtask

  task automatic test_random();
    coef_t  h [NTAPS];
    samp_t  hist [NTAPS];
    samp_t  x;
    longint acc_m;
    bit     sat;
    bit     m_ovf;
    for (int k = 0; k < NTAPS; k++) begin
      h[k]    = coef_t'(int'($urandom_range(0, 80)) - 40);
      hist[k] = '0;
    end
    load_coefs(h);
    do_clr();
    pulse_ovf_clr();
    m_ovf = 1'b0;
    for (int it = 0; it < 48; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.xin_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.yout_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL random gap yout_valid: got %b, expected 0", bus.yout_valid);
        end
      end else begin
        x   = samp_t'($urandom);
        sat = 1'($urandom);
        for (int k = NTAPS-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        acc_m = 0;
        for (int k = 0; k < NTAPS; k++) acc_m += longint'(tb_h[k]) * longint'(hist[k]);
        if (acc_m > 32767 || acc_m < -32768) m_ovf = 1'b1;
        bus.sat_en = sat;
        accept(x, sat16(acc_m, sat));
        check_ovf("random", m_ovf);
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.clr       = 1'b0;
    bus.xin_valid = 1'b0;
    bus.xin       = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.sat_en    = 1'b1;
    bus.ovf_clr   = 1'b0;

    test_reset();
    test_impulse();
    test_stall();
    test_coef_collision();
    test_saturation();
    test_reset_midstream();
    test_ovf_clr();
    test_shift();
    test_clr();
    test_random();

    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard drain: got %0d pending outputs, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fir_tdf_param.md
Name: fir_tdf_param

Overview:
- Parametrised transposed-direct-form FIR filter, the successor to the team's fixed 8-tap constant-coefficient FIR.
- Adds the following over the fixed filter:
  - generic tap count and data widths;
  - run-time coefficient load;
  - sample-valid flow control;
  - output scaling with selectable saturate or wrap;
  - sticky overflow flag;
  - synchronous pipeline flush.
- Sits between the sample source and downstream DSP stages in the kernel comparison datapath.

Parameters:
- NTAPS, 8: number of taps, 2..32.
- DW, 8: signed input sample width.
- CW, 8: signed coefficient width.
- OW, 16: signed output width.
- SHIFT, 0: arithmetic right shift applied to the accumulator before output, 0..AW-1.
- Derived, not overridable:
  - AW = DW+CW+clog2(NTAPS): accumulator width.
  - AWD = clog2(NTAPS): coefficient address width.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- Clr  in  1  synchronous flush of the delay line and output; coefficients are kept.
- Xin_valid  in  1  Xin carries a new sample this cycle.
- Xin  in  DW  signed input sample.
- Coef_we  in  1  coefficient write strobe.
- Coef_addr  in  AWD  tap index k; a value of NTAPS or more is ignored.
- Coef_data  in  CW  signed coefficient h[k].
- Sat_en  in  1  1 = saturate the output to OW, 0 = two's-complement wrap.
- Ovf_clr  in  1  clears Ovf.
- Yout_valid  out  1  Yout updated this cycle.
- Yout  out  OW  signed filter output.
- Ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - All NTAPS-1 delay registers cleared to 0.
  - Coefficients set to h[0]=1 and h[1..NTAPS-1]=0, giving identity passthrough.
  - Yout=0, Yout_valid=0, Ovf=0.
- Function: y[n] = sum over k=0..NTAPS-1 of h[k]*x[n-k], with x[n] the n-th accepted sample (a cycle with Xin_valid=1).
- Structure is transposed form:
  - product p_k = h[k]*Xin, full precision CW+DW, sign-extended to AW;
  - Q[NTAPS-1] <= p_{NTAPS-1};
  - Q[k] <= Q[k+1] + p_k for k=1..NTAPS-2;
  - acc = Q[1] + p_0, combinational.
- Flow control: Q registers and Yout update only when Xin_valid=1. A cycle with Xin_valid=0 freezes all state and drives Yout_valid=0.
- Latency: Yout and Yout_valid=1 appear on the edge after the accepting edge, i.e. 1 cycle after Xin_valid. Yout holds its value between valid pulses.
- Internal arithmetic never overflows at AW bits.
- Output formation: s = acc >>> SHIFT (arithmetic shift, truncation toward −inf). Then:
  - if s fits in OW bits: Yout=s;
  - else if Sat_en=1: Yout=+2^(OW-1)-1 or −2^(OW-1) according to the sign of s;
  - else Yout = s[OW-1:0].
- Ovf:
  - set on any accepted sample whose s does not fit in OW bits, regardless of Sat_en;
  - stays set until Ovf_clr=1;
  - if Ovf_clr and a new overflow occur in the same cycle, set wins.
- Coefficient write:
  - h[Coef_addr] <= Coef_data on the edge when Coef_we=1, independent of Xin_valid;
  - a sample accepted on that same edge uses the old coefficient, and the new value applies from the next sample;
  - writes are permitted at any time and do not flush the pipeline.
- Clr=1:
  - on the edge, all Q=0, Yout=0, Yout_valid=0;
  - takes priority over Xin_valid, so a sample presented with Clr=1 is discarded;
  - Ovf and coefficients are unaffected.
- Sat_en is sampled on the accepting edge and may change on any cycle.
- Reset asserted mid-stream aborts immediately. The first sample after release sees an all-zero history and the identity coefficients.

Test Plan:
- Impulse response:
  - load h = −2,−1,3,4,1,1,1,1;
  - Xin_valid=1 for 9 cycles with Xin = 1,0,0,0,0,0,0,0,0;
  - required: Yout = −2,−1,3,4,1,1,1,1,0 on consecutive cycles, Yout_valid=1 each cycle, 1-cycle latency.
- Stall:
  - repeat the impulse test with Xin_valid toggling 1,0,1,0…;
  - required: the same Yout sequence, emitted only on alternate cycles with Yout_valid=0 on gap cycles and Yout held between pulses.
- Saturation:
  - load all h=127 and drive Xin=127 for 8 or more valid cycles;
  - required: steady state s=129032, Sat_en=1 gives Yout=32767 with Ovf=1;
  - with Sat_en=0, Yout=−2040;
  - with all h=−128 and Xin=−128, the Sat_en=1 case gives Yout=32767.
- Ovf and scaling:
  - after overflow, pulse Ovf_clr, giving Ovf=0;
  - then, with SHIFT=1 build, identity coefficients and Xin=−3, required Yout=−2.
- Coefficient write collision:
  - with identity coefficients, write h[0]=2 on the same edge that accepts Xin=5, then accept Xin=5 again;
  - required: Yout = 5, then 10.
- Reset and Clr:
  - assert Rst_n=0 mid-stream, giving all outputs 0 immediately;
  - after release, Xin=7 gives Yout=7 (identity);
  - Clr with Xin_valid=1 discards that sample, and the next impulse response shows no residual history.
